// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use interlock, data-memory wait and EX redirect.
// Optional sticky data-memory timeout is built only when PIPE_CTRL_TIMEOUT_EN is defined.
module pipe_ctrl #(
  parameter int MAX_MEM_WAIT = 15,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_rs1_i,
  input  logic [4:0]             id_rs2_i,
  input  logic                   id_rs1_used_i,
  input  logic                   id_rs2_used_i,
  input  logic [4:0]             ex_rd_i,
  input  logic                   ex_mem_read_i,
  input  logic                   ex_redirect_i,
  input  logic                   imem_ready_i,
  input  logic                   dmem_req_i,
  input  logic                   dmem_ready_i,
  output logic                   pc_stall_o,
  output logic                   if2id_stall_o,
  output logic                   id2ex_stall_o,
  output logic                   ex2mem_stall_o,
  output logic                   if2id_flush_o,
  output logic                   id2ex_flush_o,
  output logic                   mem2wb_flush_o,
  output logic                   timeout_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, REDIRECT = 2'd2} state_t;

  state_t state, state_nxt;
  logic   load_use, mem_wait;

  assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    (((ex_rd_i == id_rs1_i) && id_rs1_used_i) ||
                     ((ex_rd_i == id_rs2_i) && id_rs2_used_i));
  assign mem_wait = dmem_req_i && !dmem_ready_i;

  always_comb begin
    pc_stall_o     = 1'b0;
    if2id_stall_o  = 1'b0;
    id2ex_stall_o  = 1'b0;
    ex2mem_stall_o = 1'b0;
    if2id_flush_o  = 1'b0;
    id2ex_flush_o  = 1'b0;
    mem2wb_flush_o = 1'b0;
    state_nxt      = RUN;
    if (rst) begin
      if2id_flush_o  = 1'b1;
      id2ex_flush_o  = 1'b1;
      mem2wb_flush_o = 1'b1;
    end else begin
      case (state)
        RUN: begin
          state_nxt = RUN;
          // Memory wait wins; EX is held, so a masked redirect/load-use re-fires later.
          if (mem_wait) begin
            {pc_stall_o, if2id_stall_o, id2ex_stall_o, ex2mem_stall_o} = 4'hF;
            mem2wb_flush_o = 1'b1;
            state_nxt      = MEM_WAIT;
          end else if (ex_redirect_i) begin
            if2id_flush_o = 1'b1;
            id2ex_flush_o = 1'b1;
            if (!imem_ready_i) state_nxt = REDIRECT;
          end else if (load_use) begin
            pc_stall_o    = 1'b1;
            if2id_stall_o = 1'b1;
            id2ex_flush_o = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!dmem_ready_i) begin
            {pc_stall_o, if2id_stall_o, id2ex_stall_o, ex2mem_stall_o} = 4'hF;
            mem2wb_flush_o = 1'b1;
            state_nxt      = MEM_WAIT;
          end
        end
        REDIRECT: begin
          if2id_flush_o = 1'b1;
          state_nxt     = imem_ready_i ? RUN : REDIRECT;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    stall_cnt_o <= '0;
    else if (pc_stall_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
  end

`ifdef PIPE_CTRL_TIMEOUT_EN
  localparam logic [7:0] MAX_W = 8'(MAX_MEM_WAIT);

  logic [7:0] wait_cnt, wait_nxt;
  logic       timeout_q;

  assign wait_nxt  = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
  assign timeout_o = timeout_q;

  // Counts stalled MEM_WAIT cycles; the flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else if ((state == MEM_WAIT) && !dmem_ready_i) begin
      wait_cnt <= wait_nxt;
      if (wait_nxt == MAX_W) timeout_q <= 1'b1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected control vectors are queued at drive time
// and popped/compared mid-cycle. Stall counter is narrowed to exercise saturation.
module tb_pipe_ctrl;
  localparam int CW = 3;
`ifdef PIPE_CTRL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // {pc_stall, if2id_stall, id2ex_stall, ex2mem_stall, if2id_flush, id2ex_flush, mem2wb_flush}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_RST  = 7'b0000111;
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_MW   = 7'b1111001;
  localparam logic [6:0] C_RD   = 7'b0000110;
  localparam logic [6:0] C_RW   = 7'b0000100;

  logic clk = 1'b0, rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_mem_read, ex_redirect;
  logic imem_ready, dmem_req, dmem_ready;
  logic pc_stall, if2id_stall, id2ex_stall, ex2mem_stall;
  logic if2id_flush, id2ex_flush, mem2wb_flush, timeout;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.MAX_MEM_WAIT(4), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read), .ex_redirect_i(ex_redirect),
    .imem_ready_i(imem_ready), .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
    .pc_stall_o(pc_stall), .if2id_stall_o(if2id_stall),
    .id2ex_stall_o(id2ex_stall), .ex2mem_stall_o(ex2mem_stall),
    .if2id_flush_o(if2id_flush), .id2ex_flush_o(id2ex_flush),
    .mem2wb_flush_o(mem2wb_flush), .timeout_o(timeout), .stall_cnt_o(stall_cnt)
  );

  wire [6:0] ctrl = {pc_stall, if2id_stall, id2ex_stall, ex2mem_stall,
                     if2id_flush, id2ex_flush, mem2wb_flush};

  typedef struct {
    string         tag;
    logic [6:0]    ctrl;
    logic [CW-1:0] cnt;
    logic          tmo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   exp_cnt = 0;
  logic exp_tmo = 1'b0;

  // Push expectation, compare at the falling edge, then advance to just past the next rising edge.
  task automatic step(input string tag, input logic [6:0] c);
    exp_t e;
    e.tag = tag; e.ctrl = c; e.cnt = CW'(exp_cnt); e.tmo = exp_tmo;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    assert (ctrl === e.ctrl) else begin
      errors++; $error("FAIL %s ctrl: got %b expected %b", e.tag, ctrl, e.ctrl);
    end
    checks++;
    assert (stall_cnt === e.cnt) else begin
      errors++; $error("FAIL %s stall_cnt: got %0d expected %0d", e.tag, stall_cnt, e.cnt);
    end
    checks++;
    assert (timeout === e.tmo) else begin
      errors++; $error("FAIL %s timeout: got %b expected %b", e.tag, timeout, e.tmo);
    end
    if (c[6] && !rst && exp_cnt < (1 << CW) - 1) exp_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step("reset", C_RST);
    rst = 1'b0;
    step("idle", C_NONE);

    // load-use via rs2
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
    step("lu_rs2", C_LU);
    idle_inputs();
    step("lu_after", C_NONE);

    // destination x0 is never a hazard
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_rs2_used = 1'b1;
    step("lu_x0", C_NONE);

    // rs1 match only counts when rs1 is read
    idle_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_rs1_used = 1'b0;
    step("lu_rs1_unused", C_NONE);
    id_rs1_used = 1'b1;
    step("lu_rs1", C_LU);
    ex_mem_read = 1'b0;
    step("lu_not_load", C_NONE);
    idle_inputs();

    // memory wait masks redirect; redirect fires after the ready cycle
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) step("mw_redir", C_MW);
    dmem_ready = 1'b1;
    step("mw_ready", C_NONE);
    dmem_req = 1'b0;
    step("redir_after_mw", C_RD);
    idle_inputs();
    step("mw_done", C_NONE);

    // redirect with two cycles of fetch wait -> three flush cycles
    ex_redirect = 1'b1; imem_ready = 1'b0;
    step("rd_0", C_RD);
    ex_redirect = 1'b0;
    step("rd_1", C_RW);
    imem_ready = 1'b1;
    step("rd_2", C_RW);
    step("rd_done", C_NONE);

    // redirect outranks load-use
    ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1;
    step("rd_over_lu", C_RD);
    idle_inputs();

    // six cycles without dmem ready; timeout visible after the 4th MEM_WAIT cycle
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (j == 5) exp_tmo = TMO_EN;
      step("tmo_wait", C_MW);
    end
    dmem_ready = 1'b1;
    step("tmo_ready", C_NONE);
    dmem_req = 1'b0;
    step("tmo_sticky", C_NONE);

    // reset in the second MEM_WAIT cycle
    dmem_req = 1'b1; dmem_ready = 1'b0;
    step("rmw_0", C_MW);
    step("rmw_1", C_MW);
    rst = 1'b1; exp_cnt = 0; exp_tmo = 1'b0;
    step("rmw_rst", C_RST);
    dmem_req = 1'b0; dmem_ready = 1'b0; rst = 1'b0;
    step("rmw_clean", C_NONE);
    idle_inputs();

    // reset in REDIRECT
    ex_redirect = 1'b1; imem_ready = 1'b0;
    step("rrd_0", C_RD);
    ex_redirect = 1'b0;
    step("rrd_1", C_RW);
    rst = 1'b1;
    step("rrd_rst", C_RST);
    rst = 1'b0;
    step("rrd_clean", C_NONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MAX_MEM_WAIT, default 15, meaning data-memory wait cycles before timeout is flagged (range 1..255).
REQ-002 SHALL have parameter STALL_CNT_W, default 16, meaning width of the stall-cycle performance counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports id_rs1_i, id_rs2_i  input  5 each  source register indices of the instruction in ID.
REQ-006 SHALL have ports id_rs1_used_i, id_rs2_used_i  input  1 each  the ID instruction reads rs1 / rs2.
REQ-007 SHALL have ports ex_rd_i  input  5  and ex_mem_read_i  input  1  destination index of the EX instruction and EX-is-load flag.
REQ-008 SHALL have port ex_redirect_i  input  1  taken branch or jump resolved in EX.
REQ-009 SHALL have ports imem_ready_i, dmem_req_i, dmem_ready_i  input  1 each  instruction-fetch ready, MEM-stage access pending, data-memory ready.
REQ-010 SHALL have ports pc_stall_o, if2id_stall_o, id2ex_stall_o, ex2mem_stall_o  output  1 each  hold the PC / pipeline buffer.
REQ-011 SHALL have ports if2id_flush_o, id2ex_flush_o, mem2wb_flush_o  output  1 each  load a bubble into that buffer.
REQ-012 SHALL have ports timeout_o  output  1  (sticky data-memory timeout) and stall_cnt_o  output  STALL_CNT_W  (stall-cycle count).

Function
REQ-013 SHALL implement a three-state FSM: RUN, MEM_WAIT, REDIRECT; all control outputs are combinational from state and current inputs (zero-cycle latency).
REQ-014 SHALL detect load-use when ex_mem_read_i=1, ex_rd_i!=0, and (ex_rd_i==id_rs1_i with id_rs1_used_i=1, or ex_rd_i==id_rs2_i with id_rs2_used_i=1).
REQ-015 SHALL treat rd = x0 as never hazardous.
REQ-016 In RUN on load-use: assert pc_stall_o, if2id_stall_o, id2ex_flush_o for exactly that cycle; FSM stays in RUN.
REQ-017 In RUN when dmem_req_i=1 and dmem_ready_i=0: assert all four stall outputs and mem2wb_flush_o; go to MEM_WAIT.
REQ-018 In MEM_WAIT: keep all stalls and mem2wb_flush_o asserted while dmem_ready_i=0; on dmem_ready_i=1, deassert everything that cycle and return to RUN.
REQ-019 In RUN on ex_redirect_i=1 (and no memory wait): assert if2id_flush_o and id2ex_flush_o; if imem_ready_i=0, go to REDIRECT.
REQ-020 In REDIRECT: assert if2id_flush_o and pc_stall_o=0 until imem_ready_i=1, then go to RUN.
REQ-021 Priority SHALL be memory wait > redirect > load-use; a suppressed redirect or load-use is re-evaluated when the wait ends because EX is held.
REQ-022 stall_cnt_o SHALL increment by 1 on every cycle that pc_stall_o=1, saturating at all-ones.
REQ-023 An unused FSM encoding SHALL return to RUN on the next edge.

Reset
REQ-024 On rst=1 (asynchronous): state=RUN, wait counter=0, stall_cnt_o=0, timeout_o=0.
REQ-025 While rst=1: all stall outputs=0; if2id_flush_o, id2ex_flush_o, mem2wb_flush_o=1.
REQ-026 Reset asserted mid-MEM_WAIT or mid-REDIRECT SHALL abandon the sequence immediately, with no residual stall after release.

Configuration
REQ-027 With PIPE_CTRL_TIMEOUT_EN defined: an 8-bit wait counter increments every MEM_WAIT cycle and clears on leaving it.
REQ-028 With PIPE_CTRL_TIMEOUT_EN defined: when the wait counter reaches MAX_MEM_WAIT, timeout_o=1 until reset; stalling continues.
REQ-029 With PIPE_CTRL_TIMEOUT_EN undefined: no wait counter is built and timeout_o is constant 0.

Verification
REQ-030 SHALL cover load-use: ex_mem_read_i=1, ex_rd_i=5, id_rs2_i=5, id_rs2_used_i=1 -> one cycle of pc_stall_o=if2id_stall_o=id2ex_flush_o=1, stall_cnt_o=1.
REQ-031 SHALL cover the x0 case: same stimulus with ex_rd_i=0 -> no stall or flush.
REQ-032 SHALL cover memory wait with redirect: dmem_req_i=1, dmem_ready_i=0 for 3 cycles while ex_redirect_i=1 -> 3 cycles of full stall, no flush of if2id/id2ex, then redirect flush on the ready cycle +1.
REQ-033 SHALL cover redirect with fetch wait: ex_redirect_i=1, imem_ready_i=0 for 2 cycles -> if2id_flush_o=1 for 3 cycles, then RUN.
REQ-034 SHALL cover timeout (macro on, MAX_MEM_WAIT=4): dmem_ready_i=0 for 6 cycles -> timeout_o rises after the 4th wait cycle and stays 1 until rst.
REQ-035 SHALL cover reset mid-wait: rst pulsed in cycle 2 of MEM_WAIT -> outputs take reset values asynchronously, and a clean RUN follows release.
